// File: rtl/rvvi_retire_scheduler.sv
// Multi-lane retire compactor feeding a single-slot RVVI sampler in program order.
// Optional backpressure counter: define RVVI_SCHED_STALL_CNT_EN.
module rvvi_retire_scheduler #(
  parameter int NRET  = 2,
  parameter int RECW  = 96,
  parameter int DEPTH = 8,
  parameter int ORDW  = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NRET-1:0]          in_valid,
  input  logic [NRET*RECW-1:0]     in_rec,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [RECW-1:0]          out_rec,
  output logic [ORDW-1:0]          out_order,
  input  logic                     out_ready,
  input  logic                     halt_req,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FREE_MAX = CW'(DEPTH - NRET);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e state_q, state_d;

  logic [RECW-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [ORDW-1:0] order_q, order_d;

  logic            accept;
  logic            push;
  logic            pop;
  logic [CW-1:0]   npush;
  logic [AW-1:0]   slot [NRET];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RUN;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:    if (halt_req)        state_d = S_DRAIN;
      S_DRAIN:  if (count_q == '0)   state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  // Output decode
  always_comb begin
    accept = 1'b0;
    halted = 1'b0;
    unique case (state_q)
      S_RUN:    accept = 1'b1;
      S_HALTED: halted = 1'b1;
      default:  ;
    endcase
  end

  assign in_ready  = accept && !halt_req && (count_q <= FREE_MAX);
  assign out_valid = (count_q != '0);
  assign push      = in_ready && (|in_valid);
  assign pop       = out_valid && out_ready;

  // Each valid lane lands after all lower valid lanes
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NRET; i++) begin
      slot[i] = wptr_q + acc[AW-1:0];
      if (in_valid[i]) acc = acc + CW'(1);
    end
    npush = acc;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NRET; i++) begin
        if (in_valid[i]) mem_q[slot[i]] <= in_rec[i*RECW +: RECW];
      end
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    order_d = order_q;
    count_d = count_q;
    if (push) begin
      wptr_d  = wptr_q + npush[AW-1:0];
      count_d = count_d + npush;
    end
    if (pop) begin
      rptr_d  = rptr_q + AW'(1);
      order_d = order_q + ORDW'(1);
      count_d = count_d - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      order_q <= ORDW'(1);
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      order_q <= order_d;
    end
  end

  assign out_rec   = mem_q[rptr_q];
  assign out_order = order_q;
  assign count     = count_q;

`ifdef RVVI_SCHED_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept && (|in_valid) && !in_ready && (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rvvi_retire_scheduler.sv
// Randomized bench for rvvi_retire_scheduler against a queue-based model.
module tb_rvvi_retire_scheduler;
  localparam int NRET  = 2;
  localparam int RECW  = 96;
  localparam int DEPTH = 8;
  localparam int ORDW  = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NRET-1:0]      in_valid;
  logic [NRET*RECW-1:0] in_rec;
  logic                 in_ready;
  logic                 out_valid;
  logic [RECW-1:0]      out_rec;
  logic [ORDW-1:0]      out_order;
  logic                 out_ready;
  logic                 halt_req;
  logic                 halted;
  logic [CW-1:0]        count;
  logic [31:0]          stall_cnt;

  int checks   = 0;
  int failures = 0;

  logic [RECW-1:0] mq [$];
  logic [ORDW-1:0] m_pops;
  bit              m_halting;
  bit              m_halted;
  logic [31:0]     m_stall;

  always #5 clk = ~clk;

  rvvi_retire_scheduler #(
    .NRET(NRET), .RECW(RECW), .DEPTH(DEPTH), .ORDW(ORDW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_rec    (in_rec),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_rec   (out_rec),
    .out_order (out_order),
    .out_ready (out_ready),
    .halt_req  (halt_req),
    .halted    (halted),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RECW-1:0] rnd_rec();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef RVVI_SCHED_STALL_CNT_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pops    = '0;
    m_halting = 1'b0;
    m_halted  = 1'b0;
    m_stall   = '0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_out_order"}, out_order, 1);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
  endtask

  // Called at posedge+1; asserts reset mid-cycle
  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    halt_req  = 1'b0;
    #2;
    model_reset();
    check_idle("rst");
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cycle(input logic [NRET-1:0] v, input bit ordy, input bit h);
    logic [RECW-1:0] r0, r1;
    bit rdy;
    int sz;
    r0 = rnd_rec();
    r1 = rnd_rec();
    in_valid  = v;
    in_rec    = {r1, r0};
    out_ready = ordy;
    halt_req  = h;
    #2;
    rdy = !m_halting && !h && ((DEPTH - mq.size()) >= NRET);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("count", count, mq.size());
    chk("out_order", out_order, m_pops + 1);
    chk("halted", halted, m_halted);
    chk("stall_cnt", stall_cnt, exp_stall());
    if (mq.size() != 0) chk("out_rec", out_rec, mq[0]);
    sz = mq.size();
    if (!m_halting && v != 0 && !rdy && m_stall != 32'hFFFF_FFFF)
      m_stall++;
    if (sz != 0 && ordy) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (rdy) begin
      if (v[0]) mq.push_back(r0);
      if (v[1]) mq.push_back(r1);
    end
    if (!m_halting) begin
      if (h) m_halting = 1'b1;
    end else if (sz == 0) begin
      m_halted = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = '0;
    in_rec    = '0;
    out_ready = 1'b0;
    halt_req  = 1'b0;
    model_reset();
    #12;
    check_idle("por");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // single-lane stream
    for (int i = 0; i < 5; i++) cycle(2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(2'b00, 1'b1, 1'b0);

    // sparse and dual lanes
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(2'b00, 1'b1, 1'b0);

    // fill to full and hold backpressure
    for (int i = 0; i < 8; i++) cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(2'b00, 1'b1, 1'b0);

    // random traffic, pointers wrap many times
    for (int i = 0; i < 400; i++)
      cycle(NRET'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, 1'b0);
    for (int i = 0; i < 100; i++)
      cycle(NRET'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, 1'b0);

    // halt with three queued records
    do_reset();
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      cycle(NRET'($urandom_range(0, 3)), 1'b1, i < 4 ? 1'b1 : 1'(($urandom & 1)));

    // reset while draining with four queued
    do_reset();
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b0);
    do_reset();
    cycle(2'b10, 1'b1, 1'b0);
    cycle(2'b00, 1'b1, 1'b0);
    cycle(2'b00, 1'b1, 1'b0);

    // random mix of halts and resets
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 40; i++)
        cycle(NRET'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
              $urandom_range(0, 30) == 0);
      do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rvvi_retire_scheduler.md
# rvvi_retire_scheduler

Retire-lane scheduler between a multi-retire trace source and the single-slot RVVI coverage sampling path. It accepts up to NRET retired-instruction records per cycle, compacts the valid lanes into a FIFO, and issues one record per cycle in program order with a monotonically increasing order tag. It also sequences end-of-trace shutdown: after a halt request it drains outstanding records and then reports halted.

## Interface
- NRET, 2: retire lanes per cycle, 1..4.
- RECW, 96: bits per record (insn, pc, trap, mode, writeback summary; opaque to this block).
- DEPTH, 8: FIFO entries; power of two, ≥ 2*NRET.
- ORDW, 64: order-tag width.

- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  NRET  per-lane record valid; lanes may be sparse.
- in_rec  in  NRET*RECW  lane i occupies bits [i*RECW +: RECW].
- in_ready  out  1  all valid lanes accepted this cycle when high.
- out_valid  out  1  head record available.
- out_rec  out  RECW  head record.
- out_order  out  ORDW  order tag of head record.
- out_ready  in  1  consumer takes head when high with out_valid.
- halt_req  in  1  stop accepting, drain, halt.
- halted  out  1  drained and stopped.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- stall_cnt  out  32  backpressure cycle count (see Configuration).

## Operation
- FSM states: RUN (reset state), DRAIN, HALTED.
  - RUN → DRAIN when halt_req=1.
  - DRAIN → HALTED when registered count==0.
  - HALTED is exited only by reset. Deasserting halt_req in DRAIN is ignored.
- in_ready = (state==RUN) && !halt_req && (DEPTH − count ≥ NRET).
  - Computed from registered count; a same-cycle pop does not raise it.
- Push occurs when in_ready && |in_valid.
  - Valid lanes are written in ascending lane index into consecutive slots starting at the write pointer. Invalid lanes consume no slot.
  - Example: in_valid=2'b10 writes only lane 1, into one slot.
- Pop occurs when out_valid && out_ready. out_valid = (count≠0). out_rec is the head slot.
- count_next = count + popcount(pushed lanes) − pop.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- out_order is the head's tag:
  - The first record after reset is tagged 1; each pop increments the tag by 1.
  - The tag wraps modulo 2^ORDW.
- halted = (state==HALTED).
- Input records offered while in_ready=0 are not consumed; the source holds them.

## Timing
- Reset values: out_valid=0, count=0, in_ready=1 (when halt_req=0), halted=0, out_order=1, stall_cnt=0, state=RUN, both pointers=0. out_rec is don't-care and is driven from slot 0.
- Latency: a record pushed at edge t is visible with out_valid=1 after t. There is no bypass.
- Throughput: one record out per cycle; up to NRET records in per cycle.
- Full boundary: with count > DEPTH−NRET, in_ready=0 even if fewer lanes are valid.
- Empty boundary: with count==0, out_valid=0 and out_ready is ignored.
- Simultaneous push and pop: both take effect; count nets out.
- halt_req and push in the same RUN cycle: the push is blocked (in_ready=0).
- Reset mid-operation: all records are discarded, the tag returns to 1, and the FSM returns to RUN immediately (asynchronous).

## Configuration
- RVVI_SCHED_STALL_CNT_EN defined:
  - stall_cnt increments by 1 in every cycle with |in_valid && !in_ready while state==RUN.
  - It saturates at 32'hFFFFFFFF and clears only on reset.
- Undefined: stall_cnt is tied to 0 and no counter flops are built.

## Test plan
- Single lane stream: in_valid=2'b01 for 5 cycles, out_ready=1 → out_order 1..5 in push order, each appearing one cycle after its push; count ≤1.
- Sparse/dual lanes: push {2'b11: A,B}, then {2'b10: C}, out_ready=0 → count=3. Then out_ready=1 → out_rec A,B,C with tags 1,2,3.
- Full/backpressure: out_ready=0 with 2'b11 pushes → count reaches 8 and in_ready drops once count >6. With RVVI_SCHED_STALL_CNT_EN defined, stall_cnt counts each blocked cycle.
- Wrap-around: 20 records through DEPTH=8 with random out_ready → all 20 delivered in order, tags contiguous, pointers wrap without loss.
- Halt: 3 records queued, then halt_req=1 → in_ready=0 from that cycle, 3 records drained, halted=1 the cycle after count hits 0. Further in_valid is ignored.
- Reset mid-drain: reset_n low in DRAIN with count=4 → count=0, out_valid=0, state RUN; the next pushed record is tagged 1.
